// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default parameters and word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned FETCH_TIMEOUT  = 15;
  localparam logic [31:0] WORD_BYTES     = 32'd4;

  // Instructions are word aligned: the low address bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/pc_adder.sv
// Combinational next-sequential-PC adder; wraps modulo 2^32.
module pc_adder
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + WORD_BYTES;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues one outstanding request at a time to
// instruction memory, captures the returned word into the fetch/decode
// register, handles branch redirects (dropping stale data) and latches a
// sticky fault when memory fails to answer within TIMEOUT cycles.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned TIMEOUT  = FETCH_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PCAddResult,
  output logic        FetchValid,
  output logic        FetchFault
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  fetch_state_e       state_q,   state_d;
  logic [31:0]        pc_q,      pc_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic               discard_q, discard_d;
  logic [31:0]        instr_q,   instr_d;
  logic [31:0]        pc_add_q,  pc_add_d;
  logic               valid_q,   valid_d;
  logic               fault_q,   fault_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic        free;

  pc_adder u_pc_adder (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  assign branch_pc = align_word(BranchTarget);
  // The fetch/decode register can take a new word if empty or draining.
  assign free      = !valid_q || !Stall;

  // Request is gated by reset so memory never sees a request while held in reset.
  assign imem_req    = Reset && (state_q == ST_IDLE) && free && !BranchTaken;
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign PCAddResult = pc_add_q;
  assign FetchValid  = valid_q;
  assign FetchFault  = fault_q;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    timer_d   = timer_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_add_d  = pc_add_q;
    fault_d   = fault_q;
    // A branch flushes the held word; otherwise it drains once decode accepts it.
    valid_d   = (BranchTaken || !Stall) ? 1'b0 : valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (BranchTaken) begin
          pc_d = branch_pc;
        end else if (free) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end

      ST_WAIT: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          if (discard_q || BranchTaken) begin
            // Returned word belongs to a redirected path: drop it.
            discard_d = 1'b0;
            if (BranchTaken) pc_d = branch_pc;
          end else begin
            instr_d  = imem_rdata;
            pc_add_d = pc_plus4;
            pc_d     = pc_plus4;
            valid_d  = 1'b1;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT)) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          if (BranchTaken) begin
            // Request already in flight: redirect now, discard its data later.
            pc_d      = branch_pc;
            discard_d = 1'b1;
          end
        end
      end

      ST_FAULT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      timer_q   <= '0;
      discard_q <= 1'b0;
      instr_q   <= '0;
      pc_add_q  <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      timer_q   <= timer_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_add_q  <= pc_add_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

endmodule
